mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single main-memory port between the instruction-cache and data-cache miss handlers of the RV32 pipeline core. Each requester asks for a line-sized burst (read for I-side, read or write-back for D-side); the arbiter grants one requester at a time, sequences the burst word by word against a memory that acknowledges each word, and signals completion. Its busy/grant outputs back the core's `ICacheMiss`/`DCacheMiss` stall inputs.

## Interface
Parameters:
- `LINE_WORDS`, 4: words per burst; power of two, at least 2.
- `IDX_W`, `$clog2(LINE_WORDS)`: word-index width.

Ports:
- `CPU_CLK`  in  1  clock; all state changes on its rising edge.
- `CPU_RST_N`  in  1  reset; asynchronous, active-low.
- `IReq`  in  1  I-side burst request, held until `IDone`.
- `IAddr`  in  32  I-side line address; bits below the line offset ignored.
- `IDone`  out  1  one-cycle completion pulse to I-side.
- `DReq`  in  1  D-side burst request, held until `DDone`.
- `DWe`  in  1  D-side burst is a write; sampled with `DReq` at grant.
- `DAddr`  in  32  D-side line address.
- `DWData`  in  32  D-side write word for the current `WordIdx`.
- `DDone`  out  1  one-cycle completion pulse to D-side.
- `GntI`, `GntD`  out  1 each  current owner; mutually exclusive.
- `WordIdx`  out  `IDX_W`  index of the word in flight.
- `RdData`  out  32  read word to the owner.
- `RdValid`  out  1  `RdData` valid this cycle.
- `MemReq`  out  1  memory request.
- `MemWe`  out  1  memory write.
- `MemAddr`  out  32  word address.
- `MemWData`  out  32  memory write data.
- `MemRData`  in  32  memory read data.
- `MemAck`  in  1  current word accepted/returned this cycle.

## Operation
- States: IDLE, XFER, DONE.
- IDLE: if any request is high, latch the winner, its line base (`Addr[31:2+IDX_W]`) and write flag (`DWe` for D, 0 for I). Clear `WordIdx`. Go to XFER.
- Arbitration: fixed priority, with D over I. A lone request always wins.
- XFER: `MemReq`=1. `MemWe` = latched write flag. `MemAddr` = {base, `WordIdx`, 2'b00}. `MemWData` = `DWData` when writing, else 0.
  - On `MemAck`, increment `WordIdx`. On a read, `RdValid` = `MemAck` and `RdData` = `MemRData` (combinational pass-through).
  - `MemAck` on word `LINE_WORDS-1` goes to DONE.
- DONE: `MemReq`=0; the owner's Done is 1 and its grant stays asserted; requests are not sampled. Next state is IDLE.
- Requester protocol: deassert Req on the edge ending the Done cycle. Req withdrawn during XFER is ignored and the burst completes.
- `WordIdx` wraps to 0 after the last word.
- Outside XFER: `RdValid`, `RdData`, `MemWData` and `MemAddr` are 0.

## Timing
- Reset (async assert): state IDLE, all registered outputs 0, `WordIdx` 0, grant and pointer cleared. An in-flight burst is abandoned with no Done. After release, IDLE samples on the first edge.
- Latency: Req high in IDLE at cycle 0 gives grant and `MemReq` at cycle 1.
  - With `MemAck` tied high, words occupy cycles 1..`LINE_WORDS` and Done is at cycle `LINE_WORDS`+1.
  - Each wait cycle (`MemAck`=0) holds address, data and `WordIdx` stable and adds one cycle.
- Back-to-back: the minimum spacing between grants is DONE plus IDLE, i.e. 2 cycles with no memory activity.
- Requests rising during XFER or DONE wait for the next IDLE.
- Grant, Done, `MemReq`, `MemWe` and `MemAddr` are registered or state-decoded with no input-to-output comb path. Only `RdData`/`RdValid` and `MemWData` are comb pass-throughs.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both requests are high in IDLE, the requester not granted last wins.
  - The last-owner pointer updates at each grant and resets to I, so D wins the first tie after reset.
  - A lone request still wins.
- `ARB_ROUND_ROBIN_EN` undefined: fixed D-over-I priority; no pointer register.

## Test plan
- `LINE_WORDS`=4, `MemAck`=1, `IReq` with `IAddr`=0x0000_1234.
  - Expect `MemAddr` 0x1230, 0x1234, 0x1238, 0x123C in cycles 1-4 and `RdValid` in each.
  - Expect `IDone` at cycle 5 and `GntI` in cycles 1-5.
- D write burst with `DAddr`=0x2000 and `DWData` = 0xA0+`WordIdx`; `MemAck` low for 2 cycles on word 1.
  - Expect `MemWe`=1, 0x2004 held 3 cycles, `DDone` at cycle 7, `RdValid` never high.
- `IReq` and `DReq` rise together and both stay pending.
  - Expect D granted first; `GntI` at 2 cycles after `DDone`.
  - With `ARB_ROUND_ROBIN_EN`: a second simultaneous pair after that goes to I, not D.
- `CPU_RST_N` pulsed low during word 2 of a read.
  - Expect immediately `MemReq`=0, grants 0, no Done.
  - After release, the still-high `IReq` restarts at word 0.
- `IReq` dropped mid-burst while `DReq` rises.
  - Expect the I burst to complete all 4 words with `IDone`, then a D grant 2 cycles later.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester line-burst arbiter between the I-cache and D-cache miss handlers and main memory.
// Define ARB_ROUND_ROBIN_EN to break I/D ties by last owner instead of fixed D-over-I priority.
module mem_bus_arbiter #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_N,
  input  logic             IReq,
  input  logic [31:0]      IAddr,
  output logic             IDone,
  input  logic             DReq,
  input  logic             DWe,
  input  logic [31:0]      DAddr,
  input  logic [31:0]      DWData,
  output logic             DDone,
  output logic             GntI,
  output logic             GntD,
  output logic [IDX_W-1:0] WordIdx,
  output logic [31:0]      RdData,
  output logic             RdValid,
  output logic             MemReq,
  output logic             MemWe,
  output logic [31:0]      MemAddr,
  output logic [31:0]      MemWData,
  input  logic [31:0]      MemRData,
  input  logic             MemAck
);

  localparam int unsigned BASE_W = 30 - IDX_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(LINE_WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic              gnt_i_q, gnt_i_d;
  logic              gnt_d_q, gnt_d_d;
  logic              we_q, we_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pick_d;
  logic              any_req;
  logic              in_xfer;
  logic              rd_xfer;

  // Word-offset bits of the request addresses are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IAddr[1+IDX_W:0], DAddr[1+IDX_W:0]};

  assign any_req = IReq | DReq;

`ifdef ARB_ROUND_ROBIN_EN
  // Last owner: 0 = I, 1 = D. Resetting to I hands the first tie to D.
  logic last_d_q;

  assign pick_d = (IReq && DReq) ? ~last_d_q : DReq;

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      last_d_q <= 1'b0;
    end else if (state_q == StIdle && any_req) begin
      last_d_q <= pick_d;
    end
  end
`else
  assign pick_d = DReq;
`endif

  always_comb begin
    state_d = state_q;
    gnt_i_d = gnt_i_q;
    gnt_d_d = gnt_d_q;
    we_d    = we_q;
    base_d  = base_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StXfer;
          gnt_d_d = pick_d;
          gnt_i_d = ~pick_d;
          we_d    = pick_d & DWe;
          base_d  = pick_d ? DAddr[31:2+IDX_W] : IAddr[31:2+IDX_W];
          idx_d   = '0;
        end
      end
      StXfer: begin
        if (MemAck) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_i_d = 1'b0;
        gnt_d_d = 1'b0;
        we_d    = 1'b0;
      end
      default: begin
        state_d = StIdle;
        gnt_i_d = 1'b0;
        gnt_d_d = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q <= StIdle;
      gnt_i_q <= 1'b0;
      gnt_d_q <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_i_q <= gnt_i_d;
      gnt_d_q <= gnt_d_d;
      we_q    <= we_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

  assign in_xfer = (state_q == StXfer);
  assign rd_xfer = in_xfer & ~we_q;

  // Only read data/valid and write data pass straight through; the rest is register-decoded.
  always_comb begin
    GntI     = gnt_i_q;
    GntD     = gnt_d_q;
    WordIdx  = idx_q;
    IDone    = (state_q == StDone) & gnt_i_q;
    DDone    = (state_q == StDone) & gnt_d_q;
    MemReq   = in_xfer;
    MemWe    = in_xfer & we_q;
    MemAddr  = in_xfer ? {base_q, idx_q, 2'b00} : 32'h0;
    MemWData = (in_xfer && we_q) ? DWData : 32'h0;
    RdValid  = rd_xfer & MemAck;
    RdData   = rd_xfer ? MemRData : 32'h0;
  end

  gnt_exclusive_a: assert property (@(posedge CPU_CLK) disable iff (!CPU_RST_N)
    !(GntI && GntD));
  req_has_owner_a: assert property (@(posedge CPU_CLK) disable iff (!CPU_RST_N)
    MemReq |-> (GntI || GntD));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed burst scenarios followed by random traffic, all outputs
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned IDX_W      = 2;

  logic             CPU_CLK = 1'b0;
  logic             CPU_RST_N = 1'b1;
  logic             IReq = 1'b0;
  logic [31:0]      IAddr = '0;
  logic             IDone;
  logic             DReq = 1'b0;
  logic             DWe = 1'b0;
  logic [31:0]      DAddr = '0;
  logic [31:0]      DWData;
  logic             DDone;
  logic             GntI, GntD;
  logic [IDX_W-1:0] WordIdx;
  logic [31:0]      RdData;
  logic             RdValid;
  logic             MemReq, MemWe;
  logic [31:0]      MemAddr, MemWData;
  logic [31:0]      MemRData = '0;
  logic             MemAck = 1'b0;

  logic             dw_follow = 1'b0;
  logic [31:0]      dw_rand = '0;

  int n_cmp = 0;
  int n_bad = 0;

  assign DWData = dw_follow ? (32'hA0 + 32'(WordIdx)) : dw_rand;

  mem_bus_arbiter #(.LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W)) dut (
    .CPU_CLK  (CPU_CLK),
    .CPU_RST_N(CPU_RST_N),
    .IReq     (IReq),
    .IAddr    (IAddr),
    .IDone    (IDone),
    .DReq     (DReq),
    .DWe      (DWe),
    .DAddr    (DAddr),
    .DWData   (DWData),
    .DDone    (DDone),
    .GntI     (GntI),
    .GntD     (GntD),
    .WordIdx  (WordIdx),
    .RdData   (RdData),
    .RdValid  (RdValid),
    .MemReq   (MemReq),
    .MemWe    (MemWe),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemRData (MemRData),
    .MemAck   (MemAck)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: owner 0 none / 1 I / 2 D, k = words already acknowledged.
  int          m_own  = 0;
  bit          m_act  = 0;
  bit          m_done = 0;
  bit          m_we   = 0;
  int          m_k    = 0;
  logic [31:0] m_base = '0;
  bit          m_last_d = 0;

  function automatic int pick_winner(input bit ireq, input bit dreq, input bit last_d);
`ifdef ARB_ROUND_ROBIN_EN
    if (ireq && dreq) return last_d ? 1 : 2;
`endif
    return dreq ? 2 : 1;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(LINE_WORDS * 4 - 1);
  endfunction

  always @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      m_own <= 0; m_act <= 0; m_done <= 0; m_we <= 0; m_k <= 0; m_base <= '0; m_last_d <= 0;
    end else if (m_done) begin
      m_done <= 0;
      m_own  <= 0;
      m_we   <= 0;
    end else if (m_act) begin
      if (MemAck) begin
        if (m_k == LINE_WORDS - 1) begin
          m_act  <= 0;
          m_done <= 1;
          m_k    <= 0;
        end else begin
          m_k <= m_k + 1;
        end
      end
    end else if (IReq || DReq) begin
      m_own    <= pick_winner(IReq, DReq, m_last_d);
      m_last_d <= (pick_winner(IReq, DReq, m_last_d) == 2);
      m_we     <= (pick_winner(IReq, DReq, m_last_d) == 2) && DWe;
      m_base   <= line_base((pick_winner(IReq, DReq, m_last_d) == 2) ? DAddr : IAddr);
      m_k      <= 0;
      m_act    <= 1;
    end
  end

  task automatic compare_outputs();
    bit e_rv;
    e_rv = m_act && !m_we && MemAck;
    check_eq("GntI",     GntI,     ((m_act || m_done) && m_own == 1));
    check_eq("GntD",     GntD,     ((m_act || m_done) && m_own == 2));
    check_eq("IDone",    IDone,    (m_done && m_own == 1));
    check_eq("DDone",    DDone,    (m_done && m_own == 2));
    check_eq("MemReq",   MemReq,   m_act);
    check_eq("MemWe",    MemWe,    (m_act && m_we));
    check_eq("MemAddr",  MemAddr,  m_act ? m_base + 32'(4 * m_k) : 32'h0);
    check_eq("MemWData", MemWData, (m_act && m_we) ? DWData : 32'h0);
    check_eq("RdValid",  RdValid,  e_rv);
    check_eq("WordIdx",  32'(WordIdx), 32'(m_k));
    if (e_rv || !m_act) check_eq("RdData", RdData, e_rv ? MemRData : 32'h0);
  endtask

  always @(negedge CPU_CLK) compare_outputs();

  task automatic next_cycle();
    @(posedge CPU_CLK);
    #1;
    MemRData = $urandom;
  endtask

  // Returns at the negedge of the requested Done cycle, or flags a timeout.
  task automatic wait_done(input bit is_d, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge CPU_CLK);
      hit = is_d ? DDone : IDone;
    end
    if (!hit) check_eq(tag, is_d ? DDone : IDone, 1);
  endtask

  logic [31:0] t2_addr [6] = '{32'h2000, 32'h2004, 32'h2004, 32'h2004, 32'h2008, 32'h200C};
  logic        t2_ack  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    bit saw_i, saw_d, exp_i;

    #1 CPU_RST_N = 1'b0;
    repeat (2) @(negedge CPU_CLK);
    #1;
    check_eq("rst_gnti", GntI, 0);
    check_eq("rst_gntd", GntD, 0);
    check_eq("rst_memreq", MemReq, 0);
    check_eq("rst_wordidx", 32'(WordIdx), 0);
    #1 CPU_RST_N = 1'b1;
    next_cycle();

    // Simultaneous requests right after reset: D first, I two cycles after DDone.
    IReq = 1; IAddr = 32'h3000; DReq = 1; DAddr = 32'h4000; DWe = 0; MemAck = 1;
    next_cycle();
    @(negedge CPU_CLK);
    check_eq("tie1_gntd", GntD, 1);
    check_eq("tie1_gnti", GntI, 0);
    wait_done(1, "tie1_ddone_timeout");
    next_cycle(); DReq = 0;
    @(negedge CPU_CLK);
    check_eq("tie1_gap_gnti", GntI, 0);
    next_cycle();
    @(negedge CPU_CLK);
    check_eq("tie1_gnti_late", GntI, 1);
    wait_done(0, "tie1_idone_timeout");
    next_cycle(); IReq = 0;
    next_cycle();

    // I read of line 0x1230, MemAck tied high.
    IReq = 1; IAddr = 32'h1234; MemAck = 1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge CPU_CLK);
      check_eq("rd_addr", MemAddr, 32'h1230 + 32'(4 * (c - 1)));
      check_eq("rd_valid", RdValid, 1);
      check_eq("rd_gnti", GntI, 1);
    end
    next_cycle();
    @(negedge CPU_CLK);
    check_eq("rd_idone", IDone, 1);
    check_eq("rd_gnti_done", GntI, 1);
    next_cycle(); IReq = 0;
    @(negedge CPU_CLK);
    check_eq("rd_idle_memreq", MemReq, 0);

    // D write-back with a two-cycle stall on word 1.
    next_cycle();
    DReq = 1; DWe = 1; DAddr = 32'h2000; dw_follow = 1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      MemAck = t2_ack[c-1];
      @(negedge CPU_CLK);
      check_eq("wr_addr", MemAddr, t2_addr[c-1]);
      check_eq("wr_we", MemWe, 1);
      check_eq("wr_data", MemWData, 32'hA0 + ((t2_addr[c-1] - 32'h2000) >> 2));
      check_eq("wr_rdvalid", RdValid, 0);
    end
    next_cycle();
    @(negedge CPU_CLK);
    check_eq("wr_ddone", DDone, 1);
    next_cycle(); DReq = 0; DWe = 0; dw_follow = 0;
    next_cycle();

    // Tie with D as last owner: round-robin hands it to I, fixed priority keeps D.
`ifdef ARB_ROUND_ROBIN_EN
    exp_i = 1;
`else
    exp_i = 0;
`endif
    IReq = 1; IAddr = 32'h3100; DReq = 1; DAddr = 32'h4100; DWe = 0;
    next_cycle();
    @(negedge CPU_CLK);
    check_eq("tie2_gnti", GntI, exp_i);
    check_eq("tie2_gntd", GntD, !exp_i);
    wait_done(!exp_i, "tie2_first_timeout");
    next_cycle();
    if (exp_i) IReq = 0; else DReq = 0;
    wait_done(exp_i, "tie2_second_timeout");
    next_cycle();
    IReq = 0; DReq = 0;
    next_cycle();

    // Reset pulse during word 2 of a read; the held IReq restarts from word 0.
    IReq = 1; IAddr = 32'h5000; MemAck = 1;
    repeat (3) next_cycle();
    #2 CPU_RST_N = 1'b0;
    #1;
    check_eq("rstmid_memreq", MemReq, 0);
    check_eq("rstmid_gnti", GntI, 0);
    check_eq("rstmid_gntd", GntD, 0);
    @(posedge CPU_CLK);
    #1;
    check_eq("rstmid_idone", IDone, 0);
    check_eq("rstmid_wordidx", 32'(WordIdx), 0);
    @(negedge CPU_CLK);
    #2 CPU_RST_N = 1'b1;
    next_cycle();
    @(negedge CPU_CLK);
    check_eq("restart_gnti", GntI, 1);
    check_eq("restart_addr", MemAddr, 32'h5000);
    wait_done(0, "restart_idone_timeout");
    next_cycle(); IReq = 0;
    next_cycle();

    // IReq withdrawn mid-burst while DReq rises: I still completes, D granted at cycle 7.
    IReq = 1; IAddr = 32'h6000; MemAck = 1;
    next_cycle();
    next_cycle();
    IReq = 0; DReq = 1; DAddr = 32'h7000; DWe = 0;
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge CPU_CLK);
    check_eq("wd_idone", IDone, 1);
    next_cycle();
    @(negedge CPU_CLK);
    check_eq("wd_gap_gntd", GntD, 0);
    next_cycle();
    @(negedge CPU_CLK);
    check_eq("wd_gntd", GntD, 1);
    check_eq("wd_daddr", MemAddr, 32'h7000);
    wait_done(1, "wd_ddone_timeout");
    next_cycle(); DReq = 0;

    // Random traffic from protocol-following requesters.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CPU_CLK);
      saw_i = IDone;
      saw_d = DDone;
      next_cycle();
      if (IReq && saw_i) IReq = 0;
      else if (!IReq && $urandom_range(0, 3) == 0) begin
        IReq = 1; IAddr = $urandom;
      end
      if (DReq && saw_d) begin
        DReq = 0; DWe = 0;
      end else if (!DReq && $urandom_range(0, 3) == 0) begin
        DReq = 1; DAddr = $urandom; DWe = 1'($urandom_range(0, 1));
      end
      MemAck  = ($urandom_range(0, 9) < 7);
      dw_rand = $urandom;
    end

    // Drain outstanding requests without raising new ones.
    for (int c = 0; c < 200 && (IReq || DReq); c++) begin
      @(negedge CPU_CLK);
      saw_i = IDone;
      saw_d = DDone;
      next_cycle();
      MemAck = 1;
      if (IReq && saw_i) IReq = 0;
      if (DReq && saw_d) begin
        DReq = 0; DWe = 0;
      end
    end
    if (IReq || DReq) check_eq("drain_timeout", 32'(MemReq), 0);
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
